// File: rtl/pe_array_ctrl_pkg.sv
// pe_array_ctrl_pkg: shared state encoding and array geometry for the PE array sequencer
package pe_array_ctrl_pkg;

    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, READOUT, DONE} state_e;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ARRAY_X = 4;
    localparam int ARRAY_Y = 4;
    localparam int N_PE    = ARRAY_X * ARRAY_Y;
    localparam int IDX_W   = clog2_min1(N_PE);
    localparam int X_W     = clog2_min1(ARRAY_X);
    localparam int Y_W     = clog2_min1(ARRAY_Y);

endpackage

// File: rtl/pe_result_mux.sv
// pe_result_mux: selects one PE accumulator out of the flattened array bus
module pe_result_mux
    import pe_array_ctrl_pkg::*;
#(
    parameter int ACC_W = 40
) (
    input  logic [N_PE*ACC_W-1:0] acc_flat_i,
    input  logic [IDX_W-1:0]      idx_i,
    output logic [ACC_W-1:0]      data_o
);

    assign data_o = acc_flat_i[int'(idx_i)*ACC_W +: ACC_W];

endmodule

// File: rtl/pe_array_ctrl.sv
// pe_array_ctrl: clears the PE array, streams a job's activations in, then reads every accumulator out
module pe_array_ctrl
    import pe_array_ctrl_pkg::*;
#(
    parameter int ACTIVATION_WIDTH  = 16,
    parameter int ACCUMULATOR_WIDTH = 40,
    parameter int LEN_WIDTH         = 16,
    parameter int PE_LATENCY        = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic [LEN_WIDTH-1:0]              cfg_len,
    input  logic                              act_valid,
    input  logic [ACTIVATION_WIDTH-1:0]       act_data,
    output logic                              act_ready,
    output logic                              pe_enable,
    output logic                              pe_clear,
    output logic [ACTIVATION_WIDTH-1:0]       pe_activations,
    input  logic [N_PE*ACCUMULATOR_WIDTH-1:0] acc_flat,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [ACCUMULATOR_WIDTH-1:0]      out_data,
    output logic [X_W-1:0]                    out_x,
    output logic [Y_W-1:0]                    out_y,
    output logic                              busy,
    output logic                              done
);

    state_e                        state_q;
    logic [LEN_WIDTH-1:0]          len_q;
    logic [LEN_WIDTH-1:0]          cnt_q;
    logic [IDX_W-1:0]              idx_q;
    logic                          pe_enable_q;
    logic                          pe_clear_q;
    logic [ACTIVATION_WIDTH-1:0]   pe_act_q;
    logic [ACCUMULATOR_WIDTH-1:0]  sel_data;

    pe_result_mux #(.ACC_W(ACCUMULATOR_WIDTH)) u_mux (
        .acc_flat_i (acc_flat),
        .idx_i      (idx_q),
        .data_o     (sel_data)
    );

    assign act_ready      = (state_q == ACCUM);
    assign out_valid      = (state_q == READOUT);
    assign busy           = (state_q != IDLE);
    assign done           = (state_q == DONE);
    assign pe_enable      = pe_enable_q;
    assign pe_clear       = pe_clear_q;
    assign pe_activations = pe_act_q;
    assign out_data       = out_valid ? sel_data : '0;
    assign out_x          = X_W'(int'(idx_q) / ARRAY_Y);
    assign out_y          = Y_W'(int'(idx_q) % ARRAY_Y);

    // Job FSM: cnt_q counts activations in ACCUM and settle cycles in DRAIN; idx_q walks the readout
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            pe_enable_q <= 1'b0;
            pe_clear_q  <= 1'b0;
            pe_act_q    <= '0;
        end else begin
            pe_enable_q <= 1'b0;
            pe_clear_q  <= 1'b0;
            if (abort && state_q != IDLE) begin
                state_q    <= IDLE;
                pe_clear_q <= 1'b1;
                cnt_q      <= '0;
                idx_q      <= '0;
            end else begin
                case (state_q)
                    IDLE: if (start && !abort) begin
                        len_q      <= cfg_len;
                        cnt_q      <= '0;
                        pe_clear_q <= 1'b1;
                        state_q    <= CLEAR;
                    end
                    CLEAR: state_q <= (len_q == '0) ? DRAIN : ACCUM;
                    ACCUM: if (act_valid) begin
                        pe_act_q    <= act_data;
                        pe_enable_q <= 1'b1;
                        cnt_q       <= (cnt_q == len_q - 1'b1) ? '0 : cnt_q + 1'b1;
                        state_q     <= (cnt_q == len_q - 1'b1) ? DRAIN : ACCUM;
                    end
                    DRAIN: begin
                        cnt_q   <= (cnt_q == LEN_WIDTH'(PE_LATENCY)) ? '0 : cnt_q + 1'b1;
                        state_q <= (cnt_q == LEN_WIDTH'(PE_LATENCY)) ? READOUT : DRAIN;
                        idx_q   <= '0;
                    end
                    READOUT: if (out_ready) begin
                        idx_q   <= (idx_q == IDX_W'(N_PE - 1)) ? '0 : idx_q + 1'b1;
                        state_q <= (idx_q == IDX_W'(N_PE - 1)) ? DONE : READOUT;
                    end
                    DONE: state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pe_array_ctrl.sv
// tb_pe_array_ctrl: drives whole jobs through the sequencer against a stand-in PE array
module tb_pe_array_ctrl;
    import pe_array_ctrl_pkg::*;

    localparam int AW = 16;
    localparam int CW = 40;
    localparam int LW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic [LW-1:0]   cfg_len = '0;
    logic            act_valid = 1'b0;
    logic [AW-1:0]   act_data = '0;
    logic            out_ready = 1'b0;
    logic            act_ready, pe_enable, pe_clear, out_valid, busy, done;
    logic [AW-1:0]   pe_activations;
    logic [N_PE*CW-1:0] acc_flat;
    logic [CW-1:0]   out_data;
    logic [X_W-1:0]  out_x;
    logic [Y_W-1:0]  out_y;

    logic [CW-1:0]   acc   [N_PE];
    logic [CW-1:0]   w     [N_PE];
    logic [CW-1:0]   exp_v [N_PE];
    logic [AW-1:0]   acts  [65536];

    int n_chk = 0;
    int n_fail = 0;

    typedef struct {
        int     len;
        int     amode;
        int     wt;
        int     vmode;
        int     rmode;
        longint expv;
    } vec_t;
    vec_t tbl [5];

    always #5 clk = ~clk;

    pe_array_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .abort          (abort),
        .cfg_len        (cfg_len),
        .act_valid      (act_valid),
        .act_data       (act_data),
        .act_ready      (act_ready),
        .pe_enable      (pe_enable),
        .pe_clear       (pe_clear),
        .pe_activations (pe_activations),
        .acc_flat       (acc_flat),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_x          (out_x),
        .out_y          (out_y),
        .busy           (busy),
        .done           (done)
    );

    // Stand-in weight-stationary array: one-cycle PE latency, weight w[i] per PE
    always @(posedge clk) begin
        for (int i = 0; i < N_PE; i++)
            if (pe_clear) acc[i] <= '0;
            else if (pe_enable) acc[i] <= acc[i] + w[i] * CW'(pe_activations);
    end

    always_comb begin
        acc_flat = '0;
        for (int i = 0; i < N_PE; i++) acc_flat[i*CW +: CW] = acc[i];
    end

    task automatic chk(input string nm, input longint got, input longint want);
        n_chk++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, got, want, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_act_ready"}, act_ready, 0);
        chk({tag, "_pe_enable"}, pe_enable, 0);
        chk({tag, "_pe_clear"}, pe_clear, 0);
        chk({tag, "_pe_act"}, pe_activations, 0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"}, out_data, 0);
        chk({tag, "_out_x"}, out_x, 0);
        chk({tag, "_out_y"}, out_y, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // Reference: every PE ends with its weight times the sum of the job's activations
    task automatic set_exp_from_model(input int len);
        longint s = 0;
        for (int k = 0; k < len; k++) s += longint'(acts[k]);
        for (int i = 0; i < N_PE; i++) exp_v[i] = CW'(longint'(w[i]) * s);
    endtask

    task automatic run_job(input int len, input int vmode, input int rmode, input int abort_at);
        int k = 0, n = 0, cyc = 0, enables = 0, clears = 0, dones = 0, budget;
        bit hs, hs_prev = 0, stall_prev = 0;
        logic [AW-1:0] last_act = '0;
        logic [CW-1:0] pd = '0;
        logic [X_W-1:0] px = '0;
        logic [Y_W-1:0] py = '0;
        budget = 2 * len + 200;
        @(negedge clk);
        start = 1'b1;
        cfg_len = LW'(len);
        while (cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (pe_enable && pe_clear) chk("en_clr_exclusive", 1, 0);
            enables += int'(pe_enable);
            clears += int'(pe_clear);
            dones += int'(done);
            if (pe_enable || hs_prev) chk("enable_follows_hs", pe_enable, hs_prev);
            if (pe_enable) chk("pe_activations", pe_activations, last_act);
            if (stall_prev) begin
                chk("stall_out_data", out_data, pd);
                chk("stall_out_x", out_x, px);
                chk("stall_out_y", out_y, py);
            end
            if (!busy) break;
            start = 1'($urandom_range(0, 1));
            cfg_len = LW'($urandom);
            act_valid = (k < len) && (vmode == 0 || cyc % 2 == 0);
            act_data = (k < len) ? acts[k] : AW'($urandom);
            hs = act_valid && act_ready;
            if (hs) begin
                last_act = act_data;
                k++;
            end
            hs_prev = hs;
            abort = abort_at >= 0 && out_valid && n == abort_at;
            out_ready = !abort && (rmode == 0 || cyc % 3 == 0);
            if (out_valid && out_ready) begin
                if (n < N_PE) begin
                    chk("out_data", out_data, exp_v[n]);
                    chk("out_x", out_x, n / ARRAY_Y);
                    chk("out_y", out_y, n % ARRAY_Y);
                end else chk("extra_output", n, N_PE - 1);
                n++;
            end
            stall_prev = out_valid && !out_ready && !abort;
            pd = out_data;
            px = out_x;
            py = out_y;
        end
        start = 1'b0;
        act_valid = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        chk("job_ends", busy, 0);
        chk("out_valid_idle", out_valid, 0);
        chk("acts_consumed", k, len);
        chk("enable_count", enables, len);
        chk("clear_count", clears, abort_at >= 0 ? 2 : 1);
        chk("output_count", n, abort_at >= 0 ? abort_at : N_PE);
        chk("done_pulses", dones, abort_at >= 0 ? 0 : 1);
        repeat (3) begin
            @(negedge clk);
            chk("idle_quiet_busy", busy, 0);
            chk("idle_quiet_done", done, 0);
        end
    endtask

    initial begin
        int i, g;
        tbl[0] = '{4, 0, 2, 0, 0, 20};
        tbl[1] = '{4, 0, 2, 1, 1, 20};
        tbl[2] = '{0, 0, 2, 0, 0, 0};
        tbl[3] = '{8, 1, 5, 0, 0, 120};
        tbl[4] = '{1, 2, 9, 1, 0, 63};

        #12;
        chk_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // Reset in the middle of ACCUM after 3 of 8 activations
        for (int j = 0; j < N_PE; j++) w[j] = 1;
        for (int k = 0; k < 8; k++) acts[k] = AW'(k + 1);
        @(negedge clk);
        start = 1'b1;
        cfg_len = 8;
        @(negedge clk);
        start = 1'b0;
        i = 0;
        g = 0;
        while (i < 3 && g < 20) begin
            act_valid = 1'b1;
            act_data = acts[i];
            if (act_ready) i++;
            @(negedge clk);
            g++;
        end
        chk("mid_accum_reached", i, 3);
        chk("mid_accum_enable", pe_enable, 1);
        act_valid = 1'b0;
        #1 rst = 1'b1;
        #1 chk_zero("async_reset");
        @(negedge clk);
        rst = 1'b0;

        // Table jobs with uniform weights and hand-computed results
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < N_PE; j++) w[j] = CW'(tbl[r].wt);
            for (int k = 0; k < tbl[r].len; k++)
                acts[k] = (tbl[r].amode == 0) ? AW'(k + 1) : (tbl[r].amode == 1) ? AW'(3) : AW'(7);
            for (int j = 0; j < N_PE; j++) exp_v[j] = CW'(tbl[r].expv);
            run_job(tbl[r].len, tbl[r].vmode, tbl[r].rmode, -1);
        end

        // Randomized jobs against the reference model
        for (int r = 0; r < 4; r++) begin
            int len;
            len = $urandom_range(1, 12);
            for (int j = 0; j < N_PE; j++) w[j] = CW'($urandom_range(0, 255));
            for (int k = 0; k < len; k++) acts[k] = AW'($urandom_range(0, 255));
            set_exp_from_model(len);
            run_job(len, r % 2, r / 2, -1);
        end

        // Abort during readout at idx 5
        for (int j = 0; j < N_PE; j++) w[j] = CW'($urandom_range(1, 100));
        for (int k = 0; k < 6; k++) acts[k] = AW'($urandom_range(0, 1000));
        set_exp_from_model(6);
        run_job(6, 0, 0, 5);

        // A clean job right after the abort
        set_exp_from_model(6);
        run_job(6, 1, 0, -1);

        // Maximum length job
        for (int j = 0; j < N_PE; j++) w[j] = 1;
        for (int k = 0; k < 65535; k++) acts[k] = 1;
        for (int j = 0; j < N_PE; j++) exp_v[j] = 65535;
        run_job(65535, 0, 0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
